// File: rtl/shift_seq_ctrl_32.sv
// shift_seq_ctrl_32: multi-cycle logical shift sequencer feeding a 32-bit
// shift-by-2 stage. An odd amount costs one internal shift-by-1 step. Every
// remaining pair of bit positions costs one pass through the external stage.
module shift_seq_ctrl_32 #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             DIR,
    input  logic [AMT_W-1:0] AMT,
    input  logic [WIDTH-1:0] DIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DOUT,
    output logic [WIDTH-1:0] ST_IN,
    input  logic [WIDTH-1:0] ST_OUT,
    output logic             L_SHIFT,
    output logic             NO_SHIFT,
    output logic             R_SHIFT
);

    localparam int PAIR_W = AMT_W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ODD,
        S_STEP,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  work_q,  work_d;
    logic [WIDTH-1:0]  dout_q,  dout_d;
    logic [PAIR_W-1:0] pairs_q, pairs_d;
    logic              dir_q,   dir_d;

    // State and datapath registers. Everything clears asynchronously, so an
    // abandoned shift leaves no partial result behind.
    // NOTE: the result register is part of the reset set. DOUT must read 0
    // while reset is held, even in the middle of an operation.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            dout_q  <= '0;
            pairs_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values present before the edge, whatever the statement order.
            state_q <= state_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
            pairs_q <= pairs_d;
            dir_q   <= dir_d;
        end
    end

    // Sequencing and working-register update. The operand, amount and
    // direction are captured once in IDLE. After that, only the latched
    // copies are used.
    always_comb begin
        // NOTE: each variable gets a hold value before the case statement.
        // A branch that does not assign it therefore cannot infer a latch.
        state_d = state_q;
        work_d  = work_q;
        pairs_d = pairs_q;
        dir_d   = dir_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    work_d  = DIN;
                    pairs_d = AMT[AMT_W-1:1];
                    dir_d   = DIR;
                    if (AMT[0]) begin
                        state_d = S_ODD;
                    end else if (AMT[AMT_W-1:1] != '0) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_ODD: begin
                work_d  = dir_q ? {work_q[WIDTH-2:0], 1'b0}
                                : {1'b0, work_q[WIDTH-1:1]};
                state_d = (pairs_q != '0) ? S_STEP : S_FIN;
            end
            S_STEP: begin
                work_d  = ST_OUT;
                pairs_d = pairs_q - PAIR_W'(1);
                if (pairs_q == PAIR_W'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result capture: DOUT takes the final working value on the edge that
    // enters FIN. It then holds that value until the next result.
    always_comb begin
        dout_d = dout_q;
        if ((state_d == S_FIN) && (state_q != S_FIN)) begin
            dout_d = work_d;
        end
    end

    // The stage controls come only from registered state, so the stage never
    // sees a glitch. Exactly one control is high in every state.
    assign L_SHIFT  = (state_q == S_STEP) &&  dir_q;
    assign R_SHIFT  = (state_q == S_STEP) && !dir_q;
    assign NO_SHIFT = (state_q != S_STEP);

    assign BUSY  = (state_q != S_IDLE);
    assign DONE  = (state_q == S_FIN);
    assign DOUT  = dout_q;
    assign ST_IN = work_q;

endmodule

// File: tb/tb_shift_seq_ctrl_32.sv
// Testbench for shift_seq_ctrl_32. A behavioural shift-by-2 stage is attached
// to ST_IN/ST_OUT. Each result is compared with a plain logical shift, and
// each latency with the formula built from the amount.
module tb_shift_seq_ctrl_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [4:0]  amt;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic [31:0] st_in;
    logic [31:0] st_out;
    logic        l_shift;
    logic        no_shift;
    logic        r_shift;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl_32 dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .START    (start),
        .DIR      (dir),
        .AMT      (amt),
        .DIN      (din),
        .BUSY     (busy),
        .DONE     (done),
        .DOUT     (dout),
        .ST_IN    (st_in),
        .ST_OUT   (st_out),
        .L_SHIFT  (l_shift),
        .NO_SHIFT (no_shift),
        .R_SHIFT  (r_shift)
    );

    // Downstream shift-by-2 stage: zero fill, one-hot controls.
    assign st_out = l_shift ? (st_in << 2) :
                    r_shift ? (st_in >> 2) : st_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one operation. The caller must be positioned just after a rising
    // edge with the DUT idle. When junk=1, inputs are scrambled every busy
    // cycle, with a START pulse in the cycle after acceptance. When
    // fin_poke=1, START is raised during FIN. The task returns just after the
    // edge that leaves FIN.
    task automatic do_op(input logic d, input logic [4:0] a, input logic [31:0] x,
                         input bit junk, input bit fin_poke);
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_l;
        int          exp_r;
        int          lcnt;
        int          rcnt;
        int          lat;
        bit          found;
        exp_res = d ? (x << a) : (x >> a);
        exp_lat = 1 + int'(a[0]) + int'(a[4:1]);
        exp_l   = d ? int'(a[4:1]) : 0;
        exp_r   = d ? 0 : int'(a[4:1]);
        lcnt = 0;
        rcnt = 0;
        lat = 0;
        found = 0;
        start = 1'b1;
        dir   = d;
        amt   = a;
        din   = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check("onehot", 32'(int'(l_shift) + int'(no_shift) + int'(r_shift)), 32'd1);
            lcnt += int'(l_shift);
            rcnt += int'(r_shift);
            if (done) begin
                found = 1;
                lat = c;
                break;
            end
            check("busy_during_op", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            if (junk) begin
                start = (c == 1);
                din   = $urandom;
                dir   = 1'($urandom);
                amt   = 5'($urandom);
            end
        end
        if (!found) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("dout", dout, exp_res);
            check("l_count", 32'(lcnt), 32'(exp_l));
            check("r_count", 32'(rcnt), 32'(exp_r));
        end
        start = 1'b0;
        if (fin_poke) begin
            start = 1'b1;
            dir   = 1'b1;
            amt   = 5'd1;
            din   = 32'hFFFF_FFFF;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_after_fin", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("dout_held", dout, exp_res);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        amt   = '0;
        din   = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_no_shift", 32'(no_shift), 32'd1);
        check("rst_l_shift", 32'(l_shift), 32'd0);
        check("rst_r_shift", 32'(r_shift), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        do_op(1'b1, 5'd0,  32'hA5A5_A5A5, 0, 0);
        do_op(1'b1, 5'd5,  32'h0000_0001, 0, 0);
        do_op(1'b0, 5'd31, 32'h8000_0000, 0, 0);
        do_op(1'b0, 5'd4,  32'hFFFF_FFFF, 0, 0);
        do_op(1'b1, 5'd3,  32'h0000_00F0, 1, 0);
        do_op(1'b0, 5'd30, 32'hC000_0000, 0, 1);
        do_op(1'b1, 5'd31, 32'h0000_0001, 0, 0);
        do_op(1'b1, 5'd2,  32'h4000_0001, 0, 0);

        // Reset held in the middle of STEP. The checks are made before any
        // further clock edge.
        start = 1'b1;
        dir   = 1'b0;
        amt   = 5'd31;
        din   = 32'h8000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_r_shift", 32'(r_shift), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_dout", dout, 32'd0);
        check("mid_rst_no_shift", 32'(no_shift), 32'd1);
        check("mid_rst_l_shift", 32'(l_shift), 32'd0);
        check("mid_rst_r_shift", 32'(r_shift), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_dout", dout, 32'd0);

        // Random operations, issued back to back.
        for (int i = 0; i < 1000; i++) begin
            do_op(1'($urandom), 5'($urandom), $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl_32.md
Name: shift_seq_ctrl_32

Overview:
Multi-cycle shift sequencer that sits directly upstream of the 32-bit shift-by-2 stage (one-hot L_SHIFT/NO_SHIFT/R_SHIFT controls, zero fill at both ends). It holds the working operand in a register, drives it onto the stage's IN bus, issues one-hot shift controls, and captures the stage's OUT bus back each cycle. Arbitrary logical shifts of 0–31 are built from one internal shift-by-1 step for odd amounts plus repeated shift-by-2 passes through the stage.

Parameters:
WIDTH, 32, datapath width; only 32 is supported, to match the stage.
AMT_W, 5, shift-amount width, equal to log2(WIDTH).

Ports:
CLK  input  1  rising-edge clock
RESET_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE
DIR  input  1  1 = left shift, 0 = right shift (logical)
AMT  input  AMT_W  shift amount, 0–31
DIN  input  WIDTH  operand
BUSY  output  1  high in ODD/STEP/FIN
DONE  output  1  one-cycle pulse, high in FIN
DOUT  output  WIDTH  result register, valid when DONE=1 and held until the next DONE
ST_IN  output  WIDTH  to stage IN; always equals the working register
ST_OUT  input  WIDTH  from stage OUT
L_SHIFT  output  1  stage control
NO_SHIFT  output  1  stage control
R_SHIFT  output  1  stage control

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE; working reg=0, DOUT=0, pair counter=0.
  - BUSY=0, DONE=0; NO_SHIFT=1, L_SHIFT=0, R_SHIFT=0.
  - Reset mid-operation abandons the shift immediately; DOUT returns to 0.
- Controls:
  - Exactly one of L_SHIFT/NO_SHIFT/R_SHIFT is high in every cycle.
  - L_SHIFT (DIR=1) or R_SHIFT (DIR=0) is high only in STEP; NO_SHIFT is high in all other states.
  - The controls are decoded from registered state only, so they are glitch-free to the stage.
- IDLE: when START=1 on a clock edge:
  - Load working reg=DIN, pairs=AMT[4:1], odd=AMT[0], and latch DIR.
  - Next state: ODD if odd=1; else STEP if pairs≠0; else FIN.
- ODD: on the edge, working reg = working reg shifted by 1 in the latched direction, zero fill. Next state: STEP if pairs≠0, else FIN.
- STEP: on each edge, working reg = ST_OUT and pairs = pairs−1. When pairs==1 on that edge, next state is FIN; otherwise stay in STEP.
- FIN: DONE=1 for this single cycle. On the edge, return to IDLE.
- DOUT is loaded on the edge that enters FIN and holds otherwise.
- Latency: DONE is high in the cycle 1+AMT[0]+AMT[4:1] edges after the START-sampling edge.
  - AMT=0 gives 1; AMT=31 gives 17.
  - Back-to-back ops: a new START is accepted in the cycle after FIN.
- START while BUSY=1 (including during FIN) is ignored; no queuing. DIN/DIR/AMT changes while busy have no effect.
- ST_OUT is assumed combinationally valid within the same cycle. The block adds no register between ST_IN and ST_OUT.
- Left-shift fill is 0 in the LSBs; right-shift fill is 0 in the MSBs. No arithmetic or rotate mode.

Test Plan:
- Reset → with RESET_N held low mid-STEP: BUSY=0, DONE=0, DOUT=0x00000000, NO_SHIFT=1, L_SHIFT=R_SHIFT=0, all asynchronously, before the next CLK edge.
- DIR=1, AMT=0, DIN=0xA5A5A5A5 → DONE 1 cycle after START, DOUT=0xA5A5A5A5, L_SHIFT never asserted.
- DIR=1, AMT=5, DIN=0x00000001 → one ODD cycle, L_SHIFT high exactly 2 cycles, DONE at cycle 4, DOUT=0x00000020.
- DIR=0, AMT=31, DIN=0x80000000 → R_SHIFT high 15 cycles, DONE at cycle 17, DOUT=0x00000001; DIR=0, AMT=4, DIN=0xFFFFFFFF → DOUT=0x0FFFFFFF.
- START pulsed again while BUSY with AMT=1, DIN=0xFFFFFFFF → ignored; the first operation's result is unchanged. Back-to-back START in the cycle after DONE is accepted.
- Every cycle of all runs (with a behavioural stage model on ST_IN/ST_OUT) → the controls are exactly one-hot, and random DIN/AMT/DIR over 1000 ops match a reference logical-shift model.
